// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and an optional first-word-fall-through read port.
module fifo_flagged #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 3,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic              rd,
  input  logic [DWIDTH-1:0] dataIn,
  output logic [DWIDTH-1:0] dataOut,
  output logic [AWIDTH:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almostEmpty,
  output logic              almostFull,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 2**AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C    = (AWIDTH+1)'(AF_LEVEL);
  localparam logic [AWIDTH:0] AE_C    = (AWIDTH+1)'(AE_LEVEL);

  logic [DWIDTH-1:0] mem_r [DEPTH];
  logic [AWIDTH-1:0] wptr_r;
  logic [AWIDTH-1:0] rptr_r;
  logic [AWIDTH:0]   count_r;
  logic [AWIDTH:0]   count_nxt_s;
  logic              overflow_r;
  logic              underflow_r;
  logic              wr_ok_s;
  logic              rd_ok_s;

  // Status decodes come from the registered count only, never from rd/wr.
  assign empty       = (count_r == '0);
  assign full        = (count_r == DEPTH_C);
  assign almostEmpty = (count_r <= AE_C);
  assign almostFull  = (count_r >= AF_C);
  assign count       = count_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;

  // A write into a full FIFO is still taken when a read frees the head slot.
  assign wr_ok_s = en & wr & (~full | rd);
  assign rd_ok_s = en & rd & ~empty;

  // Next occupancy from the accepted write/read pair.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_nxt_s = count_r + (AWIDTH+1)'(1);
      2'b01:   count_nxt_s = count_r - (AWIDTH+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) wptr_r <= wptr_r + AWIDTH'(1);
      if (rd_ok_s) rptr_r <= rptr_r + AWIDTH'(1);
      count_r     <= count_nxt_s;
      overflow_r  <= overflow_r  | (en & wr & full & ~rd);
      underflow_r <= underflow_r | (en & rd & empty);
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wptr_r] <= dataIn;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dataOut = mem_r[rptr_r];
    end else begin : g_reg
      logic [DWIDTH-1:0] dout_r;

      // Registered read port: loads the head on an accepted read, else holds.
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_r <= '0;
        end else if (rd_ok_s) begin
          dout_r <= mem_r[rptr_r];
        end
      end

      assign dataOut = dout_r;
    end
  endgenerate

endmodule

// File: doc/fifo_flagged.md
# fifo_flagged

Synchronous single-clock FIFO: parametrised successor to the basic 8-deep byte FIFO, built from the same `clk`/`rst`/`en`/`rd`/`wr` control set. Adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- sticky overflow and underflow error flags;
- a compile-time first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer that need early back-pressure warnings or zero-latency head access.

## Interface
- `DWIDTH`, default 8: data width in bits.
- `AWIDTH`, default 3: address width. Depth is `DEPTH = 2**AWIDTH`. Legal range is `AWIDTH >= 1`.
- `FWFT`, default 0: read mode. 0 = registered-read mode; 1 = first-word-fall-through.
- `AF_LEVEL`, default 6: `almostFull` asserts when `count >= AF_LEVEL`.
- `AE_LEVEL`, default 2: `almostEmpty` asserts when `count <= AE_LEVEL`. Legal only when `0 <= AE_LEVEL < AF_LEVEL <= DEPTH`.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: global enable. When 0, all state freezes and `rd`/`wr` are ignored.
- `wr`, in, 1: write request. `dataIn` is captured on the edge.
- `rd`, in, 1: read request. Pops the head entry.
- `dataIn`, in, `DWIDTH`: write data.
- `dataOut`, out, `DWIDTH`: read data.
- `count`, out, `AWIDTH+1`: number of stored entries, 0..`DEPTH`.
- `empty`, out, 1: `count == 0`.
- `full`, out, 1: `count == DEPTH`.
- `almostEmpty`, out, 1: `count <= AE_LEVEL`.
- `almostFull`, out, 1: `count >= AF_LEVEL`.
- `overflow`, out, 1: sticky. Set when a write is dropped.
- `underflow`, out, 1: sticky. Set when a read hits an empty FIFO.

## Operation
**Storage**
- `DEPTH` x `DWIDTH` memory.
- Read and write pointers are `AWIDTH` bits wide and wrap modulo `DEPTH`.
- A registered `count` of `AWIDTH+1` bits disambiguates full from empty.
- Memory contents are not reset.

**Accept rules** (all require `en = 1`)
- `wrOk = wr & (~full | rd)`.
- `rdOk = rd & ~empty`.

**Write and read**
- On `wrOk`: `mem[wptr] <= dataIn` and `wptr` increments.
- On `rdOk`: `rptr` increments.
- Count update:
  - `+1` on `wrOk & ~rdOk`;
  - `-1` on `rdOk & ~wrOk`;
  - unchanged on both or neither.

**Simultaneous `rd` and `wr`**
- FIFO empty: the write is accepted. The read is rejected and sets `underflow`. `count` goes 0 -> 1.
- FIFO full: both are accepted. `count` stays at `DEPTH`; `overflow` is not set.
- Otherwise: both are accepted and `count` is unchanged.

**Error flags**
- `overflow` sets on `en & wr & full & ~rd`. The data is dropped.
- `underflow` sets on `en & rd & empty`. `dataOut` is unchanged.
- Both flags stay set until `rst`.

**Status flags**
- `empty`, `full`, `almostEmpty` and `almostFull` decode combinationally from registered `count` only.
- They never decode from `rd`/`wr` directly.

**Read modes**
- `FWFT = 0`: `dataOut` is a register.
  - On `rdOk` it loads `mem[rptr]`.
  - Otherwise it holds its value.
- `FWFT = 1`: `dataOut = mem[rptr]` (the head entry).
  - It is valid whenever `empty = 0`.
  - It is don't-care while empty; benches must not check it then.
  - `rd` acknowledges the displayed word.

**`en = 0`**
- Pointers, memory, `count`, `dataOut` register and sticky flags all hold.
- Requests are not recorded as errors.

## Timing
**Reset values** (`rst` high at an edge; `rst` has priority over `en`, `rd` and `wr`):
- `count = 0`, `empty = 1`, `full = 0`;
- `almostEmpty = 1`, `almostFull = 0`;
- `overflow = 0`, `underflow = 0`;
- `dataOut = 0` in `FWFT = 0`;
- both pointers = 0.

**Reset mid-operation**
- In-flight contents are discarded.
- The next edge after `rst` falls accepts traffic normally.

**Latencies**
- Write to flags: after a write at edge N, `count`/`empty`/`almost*` reflect it just after edge N.
- Registered-read latency (`FWFT = 0`): `rd` asserted before edge N means `dataOut` shows the head just after edge N. That is 1 cycle.
- FWFT first-word latency: a write into an empty FIFO at edge N means the word appears on `dataOut` and `empty` falls just after edge N. After `rdOk` at edge N, the next entry is shown after edge N.

**Throughput and ordering**
- One write and one read per cycle is sustainable indefinitely.
- Ordering is strictly first in, first out across pointer wrap-around.

## Test plan
All scenarios use `DWIDTH=8`, `AWIDTH=3`, `AF_LEVEL=6`, `AE_LEVEL=2`.

1. **Reset and fill** (`FWFT=0`): reset, then write 1..8 on consecutive cycles.
   - `count` steps 1..8.
   - `almostEmpty` drops after the 3rd write.
   - `almostFull` rises after the 6th write.
   - `full` rises after the 8th write.
   - A 9th `wr` alone sets `overflow`; `count` stays 8.
2. **Drain and wrap**: read 8 times.
   - `dataOut` = 1..8, each one cycle after its `rd`.
   - `empty` rises after the 8th read.
   - A 9th `rd` sets `underflow`; `dataOut` stays 8.
   - Then write 0x0F..0x08 with `rd` high from the second write on.
   - Pointers wrap and `dataOut` returns 0x0F, 0x0E, ... in order.
3. **Simultaneous `rd`/`wr` at the boundaries**:
   - Both asserted when empty: `count` becomes 1 and `underflow` sets.
   - Both asserted when full: `count` stays 8, `overflow` stays 0, and `dataOut` = the old head.
4. **Enable gating**: with 3 entries stored, hold `en=0` and pulse `rd`/`wr` for 4 cycles.
   - `count`, `dataOut` and the flags are unchanged.
   - There is no `underflow`/`overflow`.
5. **FWFT mode** (`FWFT=1`):
   - Write 0xA5 into an empty FIFO: `dataOut = 0xA5` and `empty = 0` right after that edge.
   - Write 0x5A, then `rd`: `dataOut` becomes 0x5A one edge later.
6. **Mid-operation reset**: with 5 entries stored and both flags set, assert `rst` for one cycle.
   - All outputs return to their reset values.
   - The next write of 0x33, followed by a read, yields 0x33.
